// File: rtl/sr_asy.sv
// rtl/sr_asy.sv - clocked SR flip-flop bank with forbidden-input flag
// Optional SR_SET_PRIORITY_EN: s=r=1 sets the bit instead of holding it.
module sr_asy #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] invalid
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_invalid;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_both;

    assign w_both = s & r;

`ifdef SR_SET_PRIORITY_EN
    assign w_q_next = (r_q & ~r) | s;
`else
    // A lone r clears, a lone s sets; s=r=1 falls through to the held value.
    assign w_q_next = (r_q & ~(r & ~s)) | (s & ~r);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q       <= RESET_VAL;
            r_invalid <= '0;
        end else begin
            r_q       <= w_q_next;
            r_invalid <= w_both;
        end
    end

    assign q       = r_q;
    assign qn      = ~r_q;
    assign invalid = r_invalid;

endmodule

// File: tb/tb_sr_asy.sv
// tb/tb_sr_asy.sv - scoreboard bench for sr_asy (WIDTH=1 and WIDTH=4 instances)
module tb_sr_asy;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:0] s1, r1, q1, qn1, inv1;
    logic [3:0] s4, r4, q4, qn4, inv4;

    int checks   = 0;
    int failures = 0;

`ifdef SR_SET_PRIORITY_EN
    localparam bit SET_PRI = 1'b1;
`else
    localparam bit SET_PRI = 1'b0;
`endif

    localparam logic [3:0] RV4 = 4'b1010;

    typedef struct packed {
        logic [0:0] q1;
        logic [0:0] inv1;
        logic [3:0] q4;
        logic [3:0] inv4;
    } exp_t;

    exp_t exp_q[$];

    logic [0:0] m_q1;
    logic [3:0] m_q4;

    sr_asy #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .s(s1), .r(r1),
        .q(q1), .qn(qn1), .invalid(inv1)
    );

    sr_asy #(.WIDTH(4), .RESET_VAL(RV4)) u_dut4 (
        .clk(clk), .reset(reset), .s(s4), .r(r4),
        .q(q4), .qn(qn4), .invalid(inv4)
    );

    always #30 clk = ~clk;

    function automatic bit next_bit(bit cur, logic sv, logic rv);
        if (sv === 1'b1 && rv === 1'b1) return SET_PRI ? 1'b1 : cur;
        if (sv === 1'b1) return 1'b1;
        if (rv === 1'b1) return 1'b0;
        return cur;
    endfunction

    // Reference model: evaluates the SR truth table at every rising edge.
    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            m_q1 = 1'b0;
            m_q4 = RV4;
            e.inv1 = '0;
            e.inv4 = '0;
        end else begin
            m_q1[0] = next_bit(m_q1[0], s1[0], r1[0]);
            e.inv1[0] = s1[0] & r1[0];
            for (int i = 0; i < 4; i++) begin
                m_q4[i] = next_bit(m_q4[i], s4[i], r4[i]);
                e.inv4[i] = s4[i] & r4[i];
            end
        end
        e.q1 = m_q1;
        e.q4 = m_q4;
        exp_q.push_back(e);
    end

    task automatic cmp(string name, logic [3:0] act, logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #5;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            cmp("q1",   {3'b0, q1},   {3'b0, e.q1});
            cmp("qn1",  {3'b0, qn1},  {3'b0, ~e.q1});
            cmp("inv1", {3'b0, inv1}, {3'b0, e.inv1});
            cmp("q4",   q4,   e.q4);
            cmp("qn4",  qn4,  ~e.q4);
            cmp("inv4", inv4, e.inv4);
        end
    end

    task automatic step(bit rst, logic [0:0] a1, logic [0:0] b1, logic [3:0] a4, logic [3:0] b4);
        reset = rst;
        s1 = a1; r1 = b1; s4 = a4; r4 = b4;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        s1 = 'x; r1 = 'x; s4 = 'x; r4 = 'x;
        m_q1 = 'x;
        m_q4 = 'x;
        @(negedge clk);
        @(negedge clk);
        step(1'b1, 'x, 'x, 'x, 'x);
        // Basic walk: hold, clear, set, hold, forbidden from 1.
        step(1'b0, 1'b0, 1'b0, 4'b0001, 4'b1000);
        step(1'b0, 1'b0, 1'b0, 4'b0100, 4'b0100);
        step(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        // Forbidden from q=0.
        step(1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111);
        step(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000);
        // Reset raised between edges must not act until the next edge.
        reset = 1'b1; s1 = 1'b1; r1 = 1'b0; s4 = 4'b1111; r4 = 4'b0000;
        #1;
        cmp("async_q1", {3'b0, q1}, {3'b0, m_q1});
        cmp("async_q4", q4, m_q4);
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(15) == 0), 1'($urandom), 1'($urandom),
                 4'($urandom), 4'($urandom));
        end
        reset = 1'b0;
        @(negedge clk);
        cmp("scoreboard_drained", 4'(exp_q.size()), 4'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_asy.md
Name: sr_asy

Overview:
- Clocked SR (set/reset) flip-flop bank: WIDTH independent bits, each updated on the rising edge of clk from its own s/r pair.
- Used as a small state/flag register in control logic. Each bit can be set, cleared, or held; it also flags the forbidden s=r=1 condition.
- One clock domain; synchronous reset.

Parameters:
- WIDTH, 1, number of independent SR bits (≥1)
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits; bit i applies to lane i)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- s  input  WIDTH  per-bit set request
- r  input  WIDTH  per-bit reset (clear) request
- q  output  WIDTH  registered flip-flop state
- qn  output  WIDTH  bitwise complement of q (combinational from q)
- invalid  output  WIDTH  registered per-bit flag: s=r=1 sampled on the last edge

Behaviour:
- One clock; reset is synchronous and active-high. All state changes occur only on rising clk.
- reset=1 at a rising edge:
  - q <= RESET_VAL and invalid <= 0, so qn = ~RESET_VAL.
  - s and r are ignored, even if X/undriven.
- reset=0 at a rising edge, per bit i:
  - s=0, r=0: q[i] holds; invalid[i] <= 0.
  - s=0, r=1: q[i] <= 0; invalid[i] <= 0.
  - s=1, r=0: q[i] <= 1; invalid[i] <= 0.
  - s=1, r=1 (forbidden): invalid[i] <= 1. q[i] follows the Optional Feature rule.
- Latency: q and invalid reflect inputs sampled at edge N, visible immediately after edge N. No combinational path from s/r to q, qn or invalid.
- Reset mid-operation: reset wins over any s/r combination on the same edge.
- Bits are fully independent; no cross-lane interaction.
- Between edges, s/r changes have no effect. Glitches on s/r are harmless.
- q never goes X after the first reset edge, provided s/r are known at each sampling edge.
- Outputs before the first reset edge are undefined; the bench must apply reset first.

Optional Feature:
- Macro: SR_SET_PRIORITY_EN
- Defined: set-dominant. On s=r=1, q[i] <= 1.
- Not defined (default): on s=r=1, q[i] holds its previous value.
- In both cases invalid[i] <= 1 for that cycle. The macro affects no other behaviour.

Test Plan (WIDTH=1, RESET_VAL=0, 60 ns clock period):
- reset=1 with s,r undriven for ≥2 edges -> q=0, qn=1, invalid=0.
- Release reset; s=0,r=0 for 2 edges -> q stays 0, invalid=0.
- s=0,r=1 -> q=0 after next edge. Then s=1,r=0 -> q=1, qn=0 after next edge. Then s=0,r=0 -> q holds 1.
- From q=1, apply s=1,r=1:
  - Without SR_SET_PRIORITY_EN: q=1 (hold), invalid=1.
  - From q=0 instead: q stays 0, invalid=1.
  - With the macro: q=1 in both cases.
  - Then s=0,r=0 -> invalid returns to 0 on the next edge.
- With q=1, assert reset=1 together with s=1,r=0 -> q=0 on that edge. Change reset between edges -> q unchanged until the next rising edge (proves reset is synchronous).
- WIDTH=4, RESET_VAL=4'b1010:
  - Reset -> q=1010.
  - Then s=0001, r=1000 -> q=0011.
  - Then s=0100, r=0100 -> invalid=0100; q=0011 without the macro, 0111 with it.
